// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet datapath constants, state types and helpers
package lenet_pkg;

    localparam int DW          = 16;
    localparam int IN_LANES    = 56;
    localparam int OUT_LANES   = 24;
    localparam int N_PAIRS     = 3;
    localparam int N_ROWS      = 24;
    localparam int RD_LAT      = 2;

    localparam int CONV1_MAPS  = 2 * N_PAIRS;
    localparam int CONV1_COLS  = 24;
    localparam int POOL1_ROWS  = N_ROWS / 2;
    localparam int POOL1_COLS  = CONV1_COLS / 2;
    localparam int POOL1_WORDS = N_PAIRS * POOL1_ROWS;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } pool_state_t;

    // Upper row of a pooling window: pair*24 + 2r collapses to 2*(pair*12 + r).
    function automatic logic [6:0] pool1_rd_addr(input logic [5:0] word);
        return {word, 1'b0};
    endfunction

endpackage

// File: rtl/pool_1_if.sv
// rtl/pool_1_if.sv - fm_bram_1 read ports and fm_bram_2 write port of pool_1
interface pool_1_if #(
    parameter int DW        = 16,
    parameter int IN_LANES  = 56,
    parameter int OUT_LANES = 24
);
    logic                    fm_bram_ena;
    logic                    fm_bram_enb;
    logic [6:0]              fm_bram_addra;
    logic [6:0]              fm_bram_addrb;
    logic [IN_LANES*DW-1:0]  fm_bram_douta;
    logic [IN_LANES*DW-1:0]  fm_bram_doutb;
    logic                    fm_bram_2_we;
    logic [5:0]              fm_bram_2_addr;
    logic [OUT_LANES*DW-1:0] fm_bram_2_din;

    modport master (
        output fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
        output fm_bram_2_we, fm_bram_2_addr, fm_bram_2_din,
        input  fm_bram_douta, fm_bram_doutb
    );

    modport slave (
        input  fm_bram_ena, fm_bram_enb, fm_bram_addra, fm_bram_addrb,
        input  fm_bram_2_we, fm_bram_2_addr, fm_bram_2_din,
        output fm_bram_douta, fm_bram_doutb
    );
endinterface

// File: rtl/pool_max2.sv
// rtl/pool_max2.sv - signed max of two samples with optional ReLU clamp
module pool_max2 import lenet_pkg::*; #(
    parameter int W = DW
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                relu,
    output logic signed [W-1:0] y
);
    logic signed [W-1:0] m;

    always_comb begin
        m = (a > b) ? a : b;
        y = (relu && m[W-1]) ? '0 : m;
    end
endmodule

// File: rtl/pool_1.sv
// rtl/pool_1.sv - layer-1 ReLU + 2x2/stride-2 max pooling from fm_bram_1 into fm_bram_2
module pool_1 #(
    parameter int DW        = lenet_pkg::DW,
    parameter int IN_LANES  = lenet_pkg::IN_LANES,
    parameter int OUT_LANES = lenet_pkg::OUT_LANES,
    parameter int N_PAIRS   = lenet_pkg::N_PAIRS,
    parameter int N_ROWS    = lenet_pkg::N_ROWS,
    parameter int RD_LAT    = lenet_pkg::RD_LAT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     pool_1_en,
    output logic     pool_1_finish,
    pool_1_if.master bram
);
    import lenet_pkg::*;

    localparam int HALF_IN  = IN_LANES / 2;
    localparam int HALF_OUT = OUT_LANES / 2;
    localparam int SKIP     = HALF_IN - 2 * HALF_OUT;
    localparam int WORDS    = N_PAIRS * N_ROWS / 2;
    localparam int DLY      = RD_LAT + 2;
    localparam logic [5:0] LAST_C     = 6'(WORDS - 1);
    localparam logic [5:0] DRAIN_LAST = 6'(DLY - 1);

    pool_state_t state, state_nx;
    logic [5:0]  c, c_nx;
    logic        en_d;
    logic        rd;
    logic        abort;

    logic [DLY-1:0] vld_q;
    logic [5:0]     addr_q [DLY];

    logic signed [DW-1:0] s1_d [2][2*HALF_OUT];
    logic signed [DW-1:0] s1_q [2][2*HALF_OUT];
    logic signed [DW-1:0] s2_d [OUT_LANES];

    // Columns 24..27 of each map half are padding in fm_bram_1.
    logic [4*SKIP*DW-1:0] unused_cols;
    assign unused_cols = {bram.fm_bram_douta[HALF_IN*DW-1 -: SKIP*DW],
                          bram.fm_bram_douta[2*HALF_IN*DW-1 -: SKIP*DW],
                          bram.fm_bram_doutb[HALF_IN*DW-1 -: SKIP*DW],
                          bram.fm_bram_doutb[2*HALF_IN*DW-1 -: SKIP*DW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            c     <= '0;
        end else begin
            state <= state_nx;
            c     <= c_nx;
        end
        // Tracks the level even through reset so a held enable cannot look like a new edge.
        en_d <= pool_1_en;
    end

    // c counts read words in READ and pipeline-drain cycles in DRAIN.
    always_comb begin
        state_nx = state;
        c_nx     = c;
        rd       = 1'b0;
        abort    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pool_1_en && !en_d) begin
                    state_nx = READ;
                    c_nx     = '0;
                end
            end
            READ: begin
                rd = 1'b1;
                if (!pool_1_en) begin
                    state_nx = IDLE;
                    c_nx     = '0;
                    abort    = 1'b1;
                end else if (c == LAST_C) begin
                    state_nx = DRAIN;
                    c_nx     = '0;
                end else begin
                    c_nx = c + 6'd1;
                end
            end
            DRAIN: begin
                if (!pool_1_en) begin
                    state_nx = IDLE;
                    c_nx     = '0;
                    abort    = 1'b1;
                end else if (c == DRAIN_LAST) begin
                    state_nx = DONE;
                    c_nx     = '0;
                end else begin
                    c_nx = c + 6'd1;
                end
            end
            DONE: begin
                if (!pool_1_en) state_nx = IDLE;
            end
        endcase
    end

    assign bram.fm_bram_ena   = rd;
    assign bram.fm_bram_enb   = rd;
    assign bram.fm_bram_addra = rd ? pool1_rd_addr(c) : '0;
    assign bram.fm_bram_addrb = rd ? (pool1_rd_addr(c) | 7'd1) : '0;
    assign pool_1_finish      = (state == DONE);

    // Valid/address delay line matching BRAM latency plus the two pipeline stages.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DLY-2:0], rd};
        end
        if (rst) begin
            for (int i = 0; i < DLY; i++) addr_q[i] <= '0;
        end else begin
            addr_q[0] <= c;
            for (int i = 1; i < DLY; i++) addr_q[i] <= addr_q[i-1];
        end
    end

    assign bram.fm_bram_2_we   = vld_q[DLY-1];
    assign bram.fm_bram_2_addr = addr_q[DLY-1];

    for (genvar m = 0; m < 2; m++) begin : g_map
        for (genvar col = 0; col < 2 * HALF_OUT; col++) begin : g_s1
            pool_max2 #(.W(DW)) u_s1 (
                .a    (bram.fm_bram_douta[(m*HALF_IN+col)*DW +: DW]),
                .b    (bram.fm_bram_doutb[(m*HALF_IN+col)*DW +: DW]),
                .relu (1'b1),
                .y    (s1_d[m][col])
            );
        end
        for (genvar k = 0; k < HALF_OUT; k++) begin : g_s2
            pool_max2 #(.W(DW)) u_s2 (
                .a    (s1_q[m][2*k]),
                .b    (s1_q[m][2*k+1]),
                .relu (1'b0),
                .y    (s2_d[m*HALF_OUT+k])
            );
        end
    end

    always_ff @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            for (int col = 0; col < 2 * HALF_OUT; col++) s1_q[m][col] <= s1_d[m][col];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bram.fm_bram_2_din <= '0;
        end else begin
            for (int k = 0; k < OUT_LANES; k++) bram.fm_bram_2_din[k*DW +: DW] <= s2_d[k];
        end
    end
endmodule

// File: tb/tb_pool_1.sv
// tb/tb_pool_1.sv - self-checking bench for pool_1 with a behavioural fm_bram_1 and pooling model
module tb_pool_1;
    localparam int DW = 16, INL = 56, OUTL = 24, NW = 72, NOUT = 36;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pool_1_en = 1'b0;
    logic pool_1_finish;

    pool_1_if #(.DW(DW), .IN_LANES(INL), .OUT_LANES(OUTL)) bram ();

    pool_1 #(.DW(DW), .IN_LANES(INL), .OUT_LANES(OUTL), .N_PAIRS(3), .N_ROWS(24), .RD_LAT(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .pool_1_en     (pool_1_en),
        .pool_1_finish (pool_1_finish),
        .bram          (bram)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [6:0] a; logic [6:0] b; logic enb; } rd_t;
    typedef struct { int cyc; logic [5:0] addr; logic [OUTL*DW-1:0] din; } wr_t;
    typedef struct { logic [15:0] a, b, c, d, y; } vec_t;

    logic [INL*DW-1:0] mem [NW];
    logic [INL*DW-1:0] pa = '0, pb = '0, qa = '0, qb = '0;
    rd_t rd_q[$];
    wr_t wr_q[$];
    int  cyc = 0, fin_cyc = -1, n_cmp = 0, n_bad = 0;

    assign bram.fm_bram_douta = qa;
    assign bram.fm_bram_doutb = qb;

    // Two-stage read pipe gives a read latency of 2 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram.fm_bram_ena) pa <= mem[bram.fm_bram_addra];
        if (bram.fm_bram_enb) pb <= mem[bram.fm_bram_addrb];
        qa <= pa;
        qb <= pb;
    end

    always @(negedge clk) begin
        if (bram.fm_bram_ena)
            rd_q.push_back('{cyc, bram.fm_bram_addra, bram.fm_bram_addrb, bram.fm_bram_enb});
        if (bram.fm_bram_2_we)
            wr_q.push_back('{cyc, bram.fm_bram_2_addr, bram.fm_bram_2_din});
        if (pool_1_finish && fin_cyc < 0) fin_cyc = cyc;
    end

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int w, input int lane, input logic [15:0] v);
        mem[w][lane*DW +: DW] = v;
    endtask

    task automatic fill_random();
        for (int w = 0; w < NW; w++)
            for (int l = 0; l < INL; l++) set_lane(w, l, 16'($urandom));
    endtask

    // Each pooled output is the largest of its four window samples, floored at zero.
    function automatic logic [383:0] model_word(input int idx);
        logic [383:0] o;
        logic signed [15:0] s;
        int p, r, best, v;
        o = '0;
        p = idx / 12;
        r = idx % 12;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 12; k++) begin
                best = 0;
                for (int dw = 0; dw < 2; dw++) begin
                    for (int dc = 0; dc < 2; dc++) begin
                        s = mem[p*24 + 2*r + dw][(m*28 + 2*k + dc)*DW +: DW];
                        v = s;
                        if (v > best) best = v;
                    end
                end
                o[(m*12 + k)*DW +: DW] = best[15:0];
            end
        end
        return o;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 384'({bram.fm_bram_ena, bram.fm_bram_enb, bram.fm_bram_addra, bram.fm_bram_addrb,
                                 bram.fm_bram_2_we, bram.fm_bram_2_addr, pool_1_finish}), '0);
        chk({tag, "_din"}, bram.fm_bram_2_din, '0);
    endtask

    task automatic start_run(output int j);
        @(negedge clk);
        rd_q.delete();
        wr_q.delete();
        fin_cyc = -1;
        pool_1_en = 1'b1;
        j = cyc;
    endtask

    task automatic run_full(input string tag);
        int j;
        start_run(j);
        for (int k = 0; k < 200 && fin_cyc < 0; k++) begin
            @(negedge clk);
            #1;
        end
        chk({tag, "_fin_cyc"}, 384'(fin_cyc), 384'(j + 41));
        repeat (5) @(negedge clk);
        #1;
        chk({tag, "_hold"}, 384'({pool_1_finish, 32'(rd_q.size()), 32'(wr_q.size())}),
            384'({1'b1, 32'(NOUT), 32'(NOUT)}));
        for (int i = 0; i < rd_q.size(); i++)
            chk($sformatf("%s_rd%0d", tag, i),
                384'({32'(rd_q[i].cyc), rd_q[i].a, rd_q[i].b, rd_q[i].enb}),
                384'({32'(j + 1 + i), 7'(2*i), 7'(2*i + 1), 1'b1}));
        for (int i = 0; i < wr_q.size(); i++) begin
            chk($sformatf("%s_wa%0d", tag, i), 384'({32'(wr_q[i].cyc), wr_q[i].addr}),
                384'({32'(j + 5 + i), 6'(i)}));
            chk($sformatf("%s_wd%0d", tag, i), wr_q[i].din, model_word(i));
        end
        @(negedge clk);
        pool_1_en = 1'b0;
        chk({tag, "_fin_before_drop"}, 384'(pool_1_finish), 384'(1));
        @(negedge clk);
        #1;
        chk({tag, "_fin_after_drop"}, 384'(pool_1_finish), 384'(0));
    endtask

    initial begin
        vec_t vecs[6];
        int   j, k_ab, k_r, late, found;
        logic [383:0] exp_w;

        vecs[0] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h7FFF};
        vecs[1] = '{16'hFFFB, 16'hFFFB, 16'hFFFB, 16'hFFFB, 16'h0000};
        vecs[2] = '{16'h0003, 16'h8000, 16'hFFFF, 16'h0002, 16'h0003};
        vecs[3] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0040};
        vecs[4] = '{16'h8000, 16'h8001, 16'hFFFE, 16'h0000, 16'h0000};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

        fill_random();
        repeat (3) @(negedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        for (int w = 0; w < NW; w++)
            for (int l = 0; l < INL; l++) set_lane(w, l, 16'(w*64 + l));
        run_full("ramp");
        if (wr_q.size() > 0) begin
            chk("ramp_lane0", 384'(wr_q[0].din[0 +: DW]), 384'(65));
            chk("ramp_lane12", 384'(wr_q[0].din[12*DW +: DW]), 384'(93));
        end

        for (int w = 0; w < NW; w++)
            for (int l = 0; l < INL; l++) set_lane(w, l, 16'hFFFB);
        set_lane(5, 30, 16'd3);
        run_full("neg");
        for (int i = 0; i < wr_q.size(); i++) begin
            exp_w = (i == 2) ? (384'd3 << (13*DW)) : '0;
            chk($sformatf("neg_const%0d", i), wr_q[i].din, exp_w);
        end

        // Window at pair 1, pooled row 3, map 0, pooled column 5.
        for (int t = 0; t < 6; t++) begin
            fill_random();
            set_lane(30, 10, vecs[t].a);
            set_lane(30, 11, vecs[t].b);
            set_lane(31, 10, vecs[t].c);
            set_lane(31, 11, vecs[t].d);
            run_full($sformatf("vec%0d", t));
            if (wr_q.size() > 15)
                chk($sformatf("vec%0d_y", t), 384'(wr_q[15].din[5*DW +: DW]), 384'(vecs[t].y));
        end

        fill_random();
        start_run(j);
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clk);
            if (bram.fm_bram_ena && bram.fm_bram_addra == 7'd20) found = 1;
        end
        chk("abort_seen", 384'(found), 384'(1));
        pool_1_en = 1'b0;
        k_ab = cyc;
        @(negedge clk);
        #1;
        chk("abort_off", 384'({bram.fm_bram_ena, bram.fm_bram_enb, bram.fm_bram_2_we}), '0);
        repeat (10) @(negedge clk);
        #1;
        late = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc > k_ab) late++;
        chk("abort_late_we", 384'(late), 384'(0));
        chk("abort_wr_count", 384'(wr_q.size()), 384'(7));
        chk("abort_no_fin", 384'(fin_cyc < 0), 384'(1));
        run_full("restart");

        fill_random();
        start_run(j);
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
            @(negedge clk);
            if (bram.fm_bram_ena && bram.fm_bram_addra == 7'd70) found = 1;
        end
        chk("drain_seen", 384'(found), 384'(1));
        @(negedge clk);
        rst = 1'b1;
        k_r = cyc;
        @(negedge clk);
        #1;
        chk_idle("rst_drain");
        rst = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        late = 0;
        foreach (wr_q[i]) if (wr_q[i].cyc > k_r) late++;
        chk("rst_late_we", 384'(late), 384'(0));
        chk("rst_wr_count", 384'(wr_q.size()), 384'(33));
        chk("rst_no_fin", 384'(fin_cyc < 0), 384'(1));
        pool_1_en = 1'b0;
        repeat (2) @(negedge clk);

        for (int t = 0; t < 3; t++) begin
            fill_random();
            run_full($sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
